// File: rtl/pdm_demod.sv
// Pulse-density demodulator: counts ones over non-overlapping windows of 2^LOG2_WIN
// enabled samples and emits one scaled, saturated level per window.
module pdm_demod #(
  parameter int unsigned NBITS    = 10,
  parameter int unsigned LOG2_WIN = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             ce,
  input  logic             sync,
  output logic [NBITS-1:0] dout,
  output logic             dout_valid,
  output logic             sat
);

  // Wide enough for either the right-shifted total or the left-shifted one (max 2^NBITS).
  localparam int unsigned SW = ((LOG2_WIN > NBITS) ? LOG2_WIN : NBITS) + 1;
  localparam logic [SW-1:0] DMAX = {{(SW - NBITS){1'b0}}, {NBITS{1'b1}}};

  logic [LOG2_WIN-1:0] win_cnt_q;
  logic [LOG2_WIN:0]   ones_cnt_q;
  logic [LOG2_WIN:0]   total;
  logic [SW-1:0]       scaled;
  logic                win_last;

  assign total    = ones_cnt_q + {{LOG2_WIN{1'b0}}, din};
  assign win_last = (win_cnt_q == {LOG2_WIN{1'b1}});

  if (LOG2_WIN >= NBITS) begin : g_shr
    assign scaled = SW'(total >> (LOG2_WIN - NBITS));
  end else begin : g_shl
    assign scaled = SW'(total) << (NBITS - LOG2_WIN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_cnt_q  <= '0;
      ones_cnt_q <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      sat        <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      // sync takes priority over a coinciding window end: that window is dropped.
      if (sync) begin
        win_cnt_q  <= '0;
        ones_cnt_q <= '0;
      end else if (ce) begin
        if (win_last) begin
          win_cnt_q  <= '0;
          ones_cnt_q <= '0;
          dout_valid <= 1'b1;
          if (scaled > DMAX) begin
            dout <= '1;
            sat  <= 1'b1;
          end else begin
            dout <= scaled[NBITS-1:0];
            sat  <= 1'b0;
          end
        end else begin
          win_cnt_q  <= win_cnt_q + LOG2_WIN'(1);
          ones_cnt_q <= total;
        end
      end
    end
  end

endmodule

// File: tb/tb_pdm_demod.sv
// Directed bench for pdm_demod: constant streams, a first-order encoder model,
// ce gating, sync, async reset and two alternate window sizes.
module tb_pdm_demod;

  logic       clk = 1'b0;
  logic       rst, din, ce, sync;
  logic [9:0] dout10, dout12, dout8;
  logic       v10, v12, v8, s10, s12, s8;

  always #5 clk = ~clk;

  pdm_demod #(.NBITS(10), .LOG2_WIN(10)) dut (
    .clk(clk), .rst(rst), .din(din), .ce(ce), .sync(sync),
    .dout(dout10), .dout_valid(v10), .sat(s10)
  );
  pdm_demod #(.NBITS(10), .LOG2_WIN(12)) dut12 (
    .clk(clk), .rst(rst), .din(din), .ce(ce), .sync(sync),
    .dout(dout12), .dout_valid(v12), .sat(s12)
  );
  pdm_demod #(.NBITS(10), .LOG2_WIN(8)) dut8 (
    .clk(clk), .rst(rst), .din(din), .ce(ce), .sync(sync),
    .dout(dout8), .dout_valid(v8), .sat(s8)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int cyc, n10, n12, n8, first10, last10, gap10, pidx, mode, base, nb;
  bit ce_tog;
  logic [9:0] acc, x;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One clock edge: prepare din per stimulus mode, then sample outputs #1 after the edge.
  task automatic tick();
    logic [10:0] s;
    if (ce) begin
      case (mode)
        1: begin
          s   = {1'b0, acc} + {1'b0, x};
          din = s[10];
          acc = s[9:0];
        end
        2: begin din = ((pidx % 4) != 3); pidx++; end
        3: begin din = ((pidx % 2) == 0); pidx++; end
        default: ;
      endcase
    end
    @(posedge clk);
    #1;
    cyc++;
    if (v10) begin
      n10++;
      if (n10 == 1) first10 = cyc;
      gap10  = cyc - last10;
      last10 = cyc;
    end
    if (v12) n12++;
    if (v8) n8++;
    if (ce_tog) ce = ~ce;
  endtask

  task automatic wait_strobes(input int k, input int budget);
    int start;
    int c;
    start = n10;
    c = 0;
    while (n10 < start + k && c < budget) begin
      tick();
      c++;
    end
    if (n10 < start + k) check_val("strobe_timeout", n10 - start, k);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cyc = 0; n10 = 0; n12 = 0; n8 = 0; first10 = -1; last10 = 0; gap10 = 0;
    pidx = 0; acc = '0;
  endtask

  initial begin
    rst = 1'b1; din = 1'b0; ce = 1'b0; sync = 1'b0;
    mode = 0; ce_tog = 1'b0; x = '0; acc = '0;
    #12;
    check_val("rst_dout", dout10, 0);
    check_val("rst_valid", v10, 0);
    check_val("rst_sat", s10, 0);

    // Constant ones: every window saturates, including the short and long windows.
    do_reset();
    ce = 1'b1; din = 1'b1;
    repeat (4096) tick();
    check_val("ones_first_strobe", first10, 1024);
    check_val("ones_gap", gap10, 1024);
    check_val("ones_n10", n10, 4);
    check_val("ones_dout", dout10, 1023);
    check_val("ones_sat", s10, 1);
    check_val("ones_n8", n8, 16);
    check_val("ones_dout8", dout8, 1023);
    check_val("ones_sat8", s8, 1);
    check_val("ones_n12", n12, 1);
    check_val("ones_dout12", dout12, 1023);
    check_val("ones_sat12", s12, 1);

    // Encoder chain at several levels; the first window after a change is transitional.
    mode = 1;
    x = 10'd120; wait_strobes(2, 3000);
    check_val("enc120_dout", dout10, 120);
    check_val("enc120_sat", s10, 0);
    x = 10'd500; wait_strobes(2, 3000);
    check_val("enc500_dout", dout10, 500);
    x = 10'd900; wait_strobes(2, 3000);
    check_val("enc900_dout", dout10, 900);
    check_val("enc900_sat", s10, 0);

    // ce gated every other cycle: strobes stretch to 2048 clocks.
    x = 10'd500; ce_tog = 1'b1;
    wait_strobes(2, 6000);
    wait_strobes(1, 3000);
    check_val("ce_gap", gap10, 2048);
    check_val("ce_dout", dout10, 500);
    ce_tog = 1'b0; ce = 1'b1;

    // sync at sample 600 restarts the window.
    wait_strobes(1, 3000);
    repeat (599) tick();
    sync = 1'b1; tick(); sync = 1'b0;
    base = cyc; nb = n10;
    repeat (1023) tick();
    check_val("sync_no_strobe", n10, nb);
    tick();
    check_val("sync_restrobe", n10, nb + 1);
    check_val("sync_spacing", last10 - base, 1024);
    check_val("sync_dout", dout10, 500);

    // sync on the final sample of a window drops it; zeros then give dout=0.
    mode = 0; din = 1'b0; nb = n10;
    repeat (1023) tick();
    sync = 1'b1; tick(); sync = 1'b0;
    check_val("syncend_valid", v10, 0);
    check_val("syncend_count", n10, nb);
    check_val("syncend_hold", dout10, 500);
    repeat (1024) tick();
    check_val("zeros_count", n10, nb + 1);
    check_val("zeros_dout", dout10, 0);
    check_val("zeros_sat", s10, 0);

    // Async reset mid-window, between edges.
    din = 1'b1;
    repeat (1024) tick();
    check_val("pre_rst_dout", dout10, 1023);
    repeat (300) tick();
    #2 rst = 1'b1;
    #1;
    check_val("async_rst_dout", dout10, 0);
    check_val("async_rst_valid", v10, 0);
    check_val("async_rst_sat", s10, 0);
    #3 rst = 1'b0;
    base = cyc;
    wait_strobes(1, 2000);
    check_val("post_rst_spacing", last10 - base, 1024);
    check_val("post_rst_dout", dout10, 1023);

    // Alternate window sizes with fixed patterns.
    do_reset();
    mode = 2;
    repeat (4096) tick();
    check_val("w12_n", n12, 1);
    check_val("w12_dout", dout12, 768);
    check_val("w12_sat", s12, 0);
    do_reset();
    mode = 3;
    repeat (256) tick();
    check_val("w8_n", n8, 1);
    check_val("w8_dout", dout8, 512);
    check_val("w8_sat", s8, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
